// File: rtl/usbdev_pkg.sv
// Shared line-state encodings, FSM states and protocol limits for the
// USB device receive path.
package usbdev_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    localparam logic [2:0] STUFF_LIMIT    = 3'd6;
    localparam logic [3:0] IDLE_J_COUNT   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR_WAIT
    } rx_state_e;

    function automatic logic is_jk_change(input logic [1:0] prev, input logic [1:0] cur);
        return ((prev == LS_J) && (cur == LS_K)) || ((prev == LS_K) && (cur == LS_J));
    endfunction

endpackage

// File: rtl/usbdev_rx_dpll.sv
// Line synchroniser, low-speed polarity swap and oversampling phase tracker
// that produces one sample strobe per recovered bit.
module usbdev_rx_dpll
    import usbdev_pkg::*;
#(
    parameter int OVERSAMPLE  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LS_MODE     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp,
    input  logic       dm,
    input  logic       run,
    input  logic       start,
    output logic [1:0] line_state,
    output logic       rx_se0,
    output logic       sample
);

    localparam int            CW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] PHASE_ONE = CW'(1);
    localparam logic [CW-1:0] PHASE_MID = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] PHASE_MAX = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] dp_sync;
    logic [SYNC_STAGES-1:0] dm_sync;
    logic                   dp_line;
    logic                   dm_line;
    logic [1:0]             prev_state;
    logic [CW-1:0]          phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_sync <= '0;
            dm_sync <= '0;
        end else begin
            dp_sync <= {dp_sync[SYNC_STAGES-2:0], dp};
            dm_sync <= {dm_sync[SYNC_STAGES-2:0], dm};
        end
    end

    // Low speed idles with D- high; swapping here keeps J = (1,0) downstream.
    assign dp_line = (LS_MODE != 0) ? dm_sync[SYNC_STAGES-1] : dp_sync[SYNC_STAGES-1];
    assign dm_line = (LS_MODE != 0) ? dp_sync[SYNC_STAGES-1] : dm_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_state <= LS_SE0;
            rx_se0     <= 1'b1;
            prev_state <= LS_SE0;
        end else begin
            line_state <= {dm_line, dp_line};
            rx_se0     <= ~dp_line & ~dm_line;
            prev_state <= line_state;
        end
    end

    // Every J/K transition re-centres the phase so the strobe lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (start || (run && is_jk_change(prev_state, line_state))) begin
            phase <= PHASE_ONE;
        end else if (run) begin
            phase <= (phase == PHASE_MAX) ? '0 : phase + PHASE_ONE;
        end else begin
            phase <= '0;
        end
    end

    assign sample = run && (phase == PHASE_MID);

endmodule

// File: rtl/usbdev_rx_phy.sv
// Oversampling USB receive PHY: NRZI decode, SYNC detection, bit unstuffing
// and LSB-first byte assembly with stuff/SE1/partial-byte error reporting.
module usbdev_rx_phy
    import usbdev_pkg::*;
#(
    parameter int OVERSAMPLE  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LS_MODE     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dp_i,
    input  logic       dm_i,
    output logic [1:0] line_state,
    output logic       rx_se0,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_error
);

    rx_state_e  state;
    logic       sample;
    logic       run;
    logic       start;
    logic       bit_val;
    logic [1:0] prev_sample;
    logic [2:0] zero_cnt;
    logic [2:0] ones_cnt;
    logic [2:0] bit_cnt;
    logic [3:0] j_cnt;
    logic [6:0] shift;
    logic       err_seen;

    assign run     = (state != ST_IDLE);
    assign start   = enable && (state == ST_IDLE) && (line_state == LS_K);
    assign bit_val = (line_state == prev_sample);

    usbdev_rx_dpll #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES),
        .LS_MODE    (LS_MODE)
    ) u_dpll (
        .clk       (clk),
        .rst_n     (rst_n),
        .dp        (dp_i),
        .dm        (dm_i),
        .run       (run),
        .start     (start),
        .line_state(line_state),
        .rx_se0    (rx_se0),
        .sample    (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            prev_sample <= LS_J;
            zero_cnt    <= '0;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            j_cnt       <= '0;
            shift       <= '0;
            err_seen    <= 1'b0;
            rx_active   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_eop      <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;
            if (!enable) begin
                state     <= ST_IDLE;
                rx_active <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (line_state == LS_K) begin
                    state       <= ST_SYNC;
                    prev_sample <= LS_J;
                    zero_cnt    <= '0;
                end
            end else if (sample) begin
                prev_sample <= line_state;
                if ((line_state == LS_SE1) && (state != ST_ERR_WAIT)) begin
                    rx_error  <= 1'b1;
                    rx_active <= 1'b0;
                    state     <= ST_ERR_WAIT;
                    j_cnt     <= '0;
                end else begin
                    case (state)
                        ST_SYNC: begin
                            if (line_state == LS_SE0) begin
                                state <= ST_ERR_WAIT;
                                j_cnt <= '0;
                            end else if (!bit_val) begin
                                if (zero_cnt != 3'd7) zero_cnt <= zero_cnt + 3'd1;
                            end else if (zero_cnt >= SYNC_MIN_ZEROS) begin
                                state     <= ST_DATA;
                                rx_active <= 1'b1;
                                ones_cnt  <= 3'd1;
                                bit_cnt   <= '0;
                                err_seen  <= 1'b0;
                            end else begin
                                state <= ST_ERR_WAIT;
                                j_cnt <= '0;
                            end
                        end
                        ST_DATA: begin
                            if (line_state == LS_SE0) begin
                                state <= ST_EOP;
                                if (bit_cnt != '0) begin
                                    rx_error  <= 1'b1;
                                    rx_active <= 1'b0;
                                    err_seen  <= 1'b1;
                                end
                            end else if (ones_cnt == STUFF_LIMIT) begin
                                // Bit after six ones must be a stuffed zero.
                                if (bit_val) begin
                                    rx_error  <= 1'b1;
                                    rx_active <= 1'b0;
                                    state     <= ST_ERR_WAIT;
                                    j_cnt     <= '0;
                                end else begin
                                    ones_cnt <= '0;
                                end
                            end else begin
                                ones_cnt <= bit_val ? ones_cnt + 3'd1 : '0;
                                shift    <= {bit_val, shift[6:1]};
                                bit_cnt  <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    rx_data  <= {bit_val, shift};
                                    rx_valid <= 1'b1;
                                end
                            end
                        end
                        ST_EOP: begin
                            if (line_state == LS_J) begin
                                state     <= ST_IDLE;
                                rx_active <= 1'b0;
                                rx_eop    <= ~err_seen;
                            end else if (line_state == LS_K) begin
                                state     <= ST_ERR_WAIT;
                                j_cnt     <= '0;
                                rx_active <= 1'b0;
                                rx_error  <= ~err_seen;
                            end
                        end
                        ST_ERR_WAIT: begin
                            if (line_state == LS_J) begin
                                if (j_cnt == IDLE_J_COUNT - 4'd1) state <= ST_IDLE;
                                j_cnt <= j_cnt + 4'd1;
                            end else begin
                                j_cnt <= '0;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/usbdev_rx_phy.md
# usbdev_rx_phy

Parametrised oversampling USB receive PHY for the TinyTapeout USB device core. It samples raw D+/D- from the `ui_in`/`uio_in` pads and recovers bit timing with a digital PLL. It NRZI-decodes, detects SYNC, strips stuffed bits and assembles bytes LSB-first, handing them to the packet layer. It generalises the fixed full-speed receive path with configurable oversampling, synchroniser depth and a low-speed polarity mode, and adds stuff, SE1 and partial-byte error reporting.

## Interface
- `OVERSAMPLE`, 4: clocks per bit; even, ≥4.
- `SYNC_STAGES`, 2: metastability flops on each line input; ≥2.
- `LS_MODE`, 0: 1 swaps D+/D- before decode (low-speed J = D- high).

- `clk`  in  1  core clock, OVERSAMPLE × bit rate.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  receiver enable; low forces IDLE.
- `dp_i`  in  1  raw D+ pad.
- `dm_i`  in  1  raw D- pad.
- `line_state`  out  2  synchronised state: 00 SE0, 01 J, 10 K, 11 SE1.
- `rx_se0`  out  1  line_state == SE0.
- `rx_active`  out  1  packet in progress (SYNC seen, EOP/error not yet).
- `rx_data`  out  8  last assembled byte, held until next byte.
- `rx_valid`  out  1  1-cycle strobe, rx_data updated.
- `rx_eop`  out  1  1-cycle strobe, clean EOP completed.
- `rx_error`  out  1  1-cycle strobe, stuff/SE1/partial-byte error.

## Operation
- Sync: SYNC_STAGES flops per input, reset to 0. Then the LS_MODE swap. J = (1,0) post-swap. line_state and rx_se0 are registered from the final stage.
- DPLL: phase counter 0..OVERSAMPLE-1 wraps. Any J↔K change loads 1. A sample point fires when counter == OVERSAMPLE/2. Counting runs only outside IDLE.
- NRZI: a sample equal to the previous sample gives bit 1; a differing sample gives bit 0. The previous sample is preset to J on IDLE exit.
- FSM states are IDLE, SYNC, DATA, EOP, ERR_WAIT.
  - IDLE: K seen → SYNC, counter loads 1.
  - SYNC: counts consecutive 0 bits. A 1 after ≥5 zeros → DATA, rx_active=1, ones counter=1. A 1 after <5 zeros → ERR_WAIT without rx_error.
  - DATA: the ones counter increments on 1 and clears on 0. After 6 ones, the next bit is discarded if 0. If it is 1: rx_error, → ERR_WAIT. Unstuffed bits shift into the byte register LSB-first. The 8th bit loads rx_data and pulses rx_valid.
  - DATA, SE0 sample: → EOP. A non-zero bit count pulses rx_error at that moment.
  - EOP: a J sample → rx_eop pulse (unless the error already pulsed), → IDLE.
  - SE1 sample in SYNC, DATA or EOP: rx_error, → ERR_WAIT.
  - ERR_WAIT: → IDLE after J is held for 8 consecutive sample points.
- rx_active drops in the same cycle as rx_eop or rx_error, and on ERR_WAIT entry from SYNC.
- rx_eop and rx_error never pulse in the same cycle.
- enable low: FSM → IDLE and all strobes/rx_active 0 on the next clock. rx_data and line_state are unaffected.

## Timing
- Reset values: line_state 00, rx_se0 1 once reset is applied. All other outputs 0. FSM is IDLE.
- Pad to line_state: SYNC_STAGES+1 clocks.
- Sample point to rx_valid/rx_error/rx_eop: 1 clock, registered.
- Bit-width tolerance: edges re-centre the DPLL. A run of 7 bits (6 ones + stuff) must decode with ±1 clock jitter per edge at OVERSAMPLE=4.
- rx_valid minimum spacing: 8×OVERSAMPLE clocks. There is no backpressure; the consumer must accept each strobe.
- Async reset mid-packet: all state cleared immediately. The next packet is received normally.

## Structure
- `usbdev_pkg`: line-state encoding constants, FSM state enum, SYNC_MIN_ZEROS=5, STUFF_LIMIT=6, IDLE_J_COUNT=8.
- Sub-module `usbdev_rx_dpll`: owns the synchroniser, the LS swap, line_state, the phase counter and the sample strobe. The top level owns NRZI, the FSM, unstuffing and byte assembly.

## Test plan
- Clean packet at OVERSAMPLE=4: SYNC, byte 0xA5, SE0×2 bits, J → rx_active high, one rx_valid with rx_data=0xA5, rx_eop pulse, rx_error never high.
- Stuffing: bytes 0xFF, 0xFF with stuffed zeros after each 6 ones → two rx_valid, both 0xFF, no error.
- Stuff error: 7 consecutive ones after SYNC → rx_error 1 clock, rx_active 0, no rx_valid. Back in IDLE after 8 J bits; the next good packet is received.
- Jitter: 0x3C sent with bit widths alternating 3 and 5 clocks → rx_data=0x3C.
- Partial byte: 12 data bits then SE0 → one rx_valid, then rx_error at EOP, no rx_eop.
- LS_MODE=1 with swapped pads, sending 0x5A, and rst_n pulsed mid-byte in a second packet → first gives 0x5A. The reset clears all outputs within 0 clocks, and a third packet decodes correctly.
